freq_meas_core: RTL and testbench

- Single-clock front end for the frequency-meter board. It bundles three functions:
  - button debounce (btn_deb function);
  - 100 kHz scan-clock divider (div_clk function);
  - a key-selected test-frequency generator plus a 1-second gated frequency counter (freq_test function).
- It sits between the board key/key-counter and the 4-digit seven-segment mux/decoders.
- It delivers 4 BCD digits of the measured frequency in Hz.

---
 rtl/freq_meas_core.sv | 189 ++++++++++++++++++
 tb/tb_freq_meas_core.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/freq_meas_core.sv
// Frequency-meter front end: per-bit button debounce, 100 kHz scan-clock
// divider, key-selected test-tone generator and a 1-second gated BCD
// frequency counter whose result drives four seven-segment digits.
module freq_meas_core #(
   parameter int CLK_FRE    = 12_000_000,
   parameter int BT_WIDTH   = 1,
   parameter int DEB_CYCLES = CLK_FRE / 50,
   parameter int F_STEP     = 500
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BT_WIDTH-1:0] btn_in,
   input  logic [3:0]          key_times,
   output logic [BT_WIDTH-1:0] btn_out,
   output logic                clk_100khz,
   output logic [3:0]          seg0,
   output logic [3:0]          seg1,
   output logic [3:0]          seg2,
   output logic [3:0]          seg3,
   output logic                freq_out
);

   // Debounce counter sizing; a counter of at least one bit keeps tiny
   // DEB_CYCLES values legal.
   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   // Half period of the scan clock in system cycles; clamped to one so
   // that slow simulation clocks still produce a toggling output.
   localparam int HALF_RAW = CLK_FRE / 200_000;
   localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
   localparam int HALF_W   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

   // Phase accumulator holds values below CLK_FRE; one extra bit absorbs
   // acc + 2f before the wrap subtraction.
   localparam int ACC_W = $clog2(CLK_FRE) + 1;
   localparam logic [ACC_W-1:0] ACC_MOD = ACC_W'(CLK_FRE);
   localparam logic [ACC_W-1:0] STEP2   = ACC_W'(2 * F_STEP);

   // Gate counter spans exactly one second of system clock.
   localparam int GATE_W = $clog2(CLK_FRE);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(CLK_FRE - 1);

   // ------------------------------------------------------------------
   // Button debounce, one independent counter per key
   // ------------------------------------------------------------------
   for (genvar i = 0; i < BT_WIDTH; i++) begin : g_deb
      logic [DEB_W-1:0] cnt;
      logic             q;

      // Count cycles of disagreement; adopt the input once it has been
      // stable for DEB_CYCLES cycles, forget shorter glitches.
      always_ff @(posedge clk or posedge rst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples pre-edge values regardless of block ordering.
         if (rst) begin
            cnt <= '0;
            q   <= 1'b1;
         end else if (btn_in[i] == q) begin
            cnt <= '0;
         end else if (cnt == DEB_LAST) begin
            q   <= btn_in[i];
            cnt <= '0;
         end else begin
            cnt <= cnt + DEB_W'(1);
         end
      end

      assign btn_out[i] = q;
   end

   // ------------------------------------------------------------------
   // Scan-clock divider
   // ------------------------------------------------------------------
   logic [HALF_W-1:0] div_cnt;

   // Toggle the scan clock every HALF cycles for a ~50% duty output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt    <= '0;
         clk_100khz <= 1'b0;
      end else if (div_cnt == HALF_LAST) begin
         div_cnt    <= '0;
         clk_100khz <= ~clk_100khz;
      end else begin
         div_cnt <= div_cnt + HALF_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Key tracking, tone generator and gated counter
   // ------------------------------------------------------------------
   logic [3:0]        key_r;
   logic [3:0]        key_prev;
   logic              key_chg;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  step;
   logic [ACC_W-1:0]  acc_sum;
   logic [ACC_W-1:0]  acc_nxt;
   logic              wrap;
   logic              rise;
   logic [GATE_W-1:0] gate_cnt;
   logic              gate_end;
   logic [15:0]       bcd_cnt;
   logic [15:0]       bcd_nxt;
   logic [15:0]       seg_q;

   // Four-digit BCD increment with decimal carry, saturating at 9999.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v == 16'h9999) return v;
      for (int d = 0; d < 4; d++) begin
         if (carry) begin
            if (r[4*d +: 4] == 4'd9) begin
               r[4*d +: 4] = 4'd0;
            end else begin
               r[4*d +: 4] = r[4*d +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Accumulator step, wrap detection and next BCD count for this cycle.
   always_comb begin
      // NOTE: every always_comb output gets an unconditional value first,
      // so no path can leave a signal unassigned and infer a latch.
      step     = (ACC_W'(key_r) + ACC_W'(1)) * STEP2;
      acc_sum  = acc + step;
      wrap     = (acc_sum >= ACC_MOD);
      acc_nxt  = wrap ? (acc_sum - ACC_MOD) : acc_sum;
      rise     = wrap & ~freq_out;
      bcd_nxt  = rise ? bcd_inc(bcd_cnt) : bcd_cnt;
      gate_end = (gate_cnt == GATE_LAST);
      key_chg  = (key_r != key_prev);
   end

   // Register the key selection and run the phase accumulator; a key
   // change restarts the tone from phase zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_r    <= 4'd0;
         key_prev <= 4'd0;
         acc      <= '0;
         freq_out <= 1'b0;
      end else begin
         key_r    <= key_times;
         key_prev <= key_r;
         if (key_chg) begin
            acc      <= '0;
            freq_out <= 1'b0;
         end else begin
            acc <= acc_nxt;
            if (wrap) freq_out <= ~freq_out;
         end
      end
   end

   // Count rising tone edges over a one-second gate and publish the count
   // at gate end; a key change discards the partial gate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_cnt <= '0;
         bcd_cnt  <= 16'h0000;
         seg_q    <= 16'h0000;
      end else if (key_chg) begin
         gate_cnt <= '0;
         bcd_cnt  <= 16'h0000;
      end else if (gate_end) begin
         seg_q    <= bcd_nxt;
         gate_cnt <= '0;
         bcd_cnt  <= 16'h0000;
      end else begin
         gate_cnt <= gate_cnt + GATE_W'(1);
         bcd_cnt  <= bcd_nxt;
      end
   end

   assign seg0 = seg_q[3:0];
   assign seg1 = seg_q[7:4];
   assign seg2 = seg_q[11:8];
   assign seg3 = seg_q[15:12];

endmodule

// File: tb/tb_freq_meas_core.sv
// Directed bench for freq_meas_core. The main instance uses a short gate
// (CLK_FRE=17000, DEB_CYCLES=50, F_STEP=500) so whole measurements fit in a
// short run; a second instance at the default 12 MHz exercises the 60-cycle
// scan-clock half period.
module tb_freq_meas_core;

   localparam int CLK_FRE = 17000;

   logic       clk;
   logic       rst;
   logic [0:0] btn_in;
   logic [3:0] key_times;

   logic [0:0] btn_out;
   logic       clk_100khz;
   logic [3:0] seg0, seg1, seg2, seg3;
   logic       freq_out;

   logic [0:0] d_btn_out;
   logic       d_clk_100khz;
   logic [3:0] d_seg0, d_seg1, d_seg2, d_seg3;
   logic       d_freq_out;

   int checks   = 0;
   int failures = 0;
   int cyc;
   int rise_cnt;
   logic prev_fo;

   freq_meas_core #(
      .CLK_FRE(CLK_FRE), .BT_WIDTH(1), .DEB_CYCLES(50), .F_STEP(500)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .key_times(key_times),
      .btn_out(btn_out), .clk_100khz(clk_100khz),
      .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
      .freq_out(freq_out)
   );

   freq_meas_core #(
      .CLK_FRE(12_000_000)
   ) dut_div (
      .clk(clk), .rst(rst), .btn_in(btn_in), .key_times(key_times),
      .btn_out(d_btn_out), .clk_100khz(d_clk_100khz),
      .seg0(d_seg0), .seg1(d_seg1), .seg2(d_seg2), .seg3(d_seg3),
      .freq_out(d_freq_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges since reset release.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and count tone rising edges.
   task automatic step();
      @(negedge clk);
      if (freq_out === 1'b1 && prev_fo === 1'b0) rise_cnt++;
      prev_fo = freq_out;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   function automatic logic [31:0] seg_val();
      return {16'h0, seg3, seg2, seg1, seg0};
   endfunction

   initial begin
      int hi_cnt;
      int div_rises;
      logic div_prev;

      rst       = 1'b0;
      btn_in    = 1'b1;
      key_times = 4'd0;
      rise_cnt  = 0;
      prev_fo   = 1'b0;

      // Asynchronous reset applied between clock edges.
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_btn_out", 32'(btn_out), 32'h1);
      check("rst_clk_100khz", 32'(clk_100khz), 32'h0);
      check("rst_div_clk_100khz", 32'(d_clk_100khz), 32'h0);
      check("rst_freq_out", 32'(freq_out), 32'h0);
      check("rst_seg", seg_val(), 32'h0000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Scan clock: high for 60 cycles, low for 60, ten periods in 1200.
      hi_cnt    = 0;
      div_rises = 0;
      div_prev  = 1'b0;
      for (int k = 1; k <= 1200; k++) begin
         step();
         check("div_level", 32'(d_clk_100khz), 32'((k / 60) % 2));
         if (d_clk_100khz === 1'b1) hi_cnt++;
         if (d_clk_100khz === 1'b1 && div_prev === 1'b0) div_rises++;
         div_prev = d_clk_100khz;
      end
      check("div_high_cycles", 32'(hi_cnt), 32'd600);
      check("div_periods", 32'(div_rises), 32'd10);

      // 30-cycle glitch never reaches btn_out.
      btn_in = 1'b0;
      for (int k = 0; k < 30; k++) begin
         step();
         check("deb_glitch", 32'(btn_out), 32'h1);
      end
      btn_in = 1'b1;
      repeat (5) step();
      check("deb_after_glitch", 32'(btn_out), 32'h1);

      // Stable low: output falls on the 50th edge after the change.
      btn_in = 1'b0;
      repeat (49) step();
      check("deb_edge49", 32'(btn_out), 32'h1);
      step();
      check("deb_edge50", 32'(btn_out), 32'h0);
      btn_in = 1'b1;

      // First gate at key 0: 500 Hz published on edge CLK_FRE.
      run_to(CLK_FRE - 1);
      check("gate1_before", seg_val(), 32'h0000);
      step();
      check("gate1_seg", seg_val(), 32'h0500);
      check("gate1_rises", 32'(rise_cnt), 32'd500);

      // Key 15 mid-gate: registered on the next edge, detected one later.
      run_to(CLK_FRE + 1000);
      key_times = 4'd15;
      step();
      step();
      check("key_chg_clears_tone", 32'(freq_out), 32'h0);
      run_to(2 * CLK_FRE + 1);
      check("key_no_partial", seg_val(), 32'h0500);
      run_to(CLK_FRE + 1002 + CLK_FRE - 1);
      check("key_hold", seg_val(), 32'h0500);
      step();
      check("key15_seg", seg_val(), 32'h8000);

      // Key 3 for two consecutive gates, each 2000 Hz.
      key_times = 4'd3;
      run_to(cyc + 2 + CLK_FRE - 1);
      check("key3_hold", seg_val(), 32'h8000);
      step();
      check("key3_gate1", seg_val(), 32'h2000);
      rise_cnt = 0;
      run_to(cyc + CLK_FRE - 1);
      check("key3_between", seg_val(), 32'h2000);
      step();
      check("key3_gate2", seg_val(), 32'h2000);
      check("key3_rises", 32'(rise_cnt), 32'd2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
